// File: rtl/pio_out_pulse.sv
// pio_out_pulse: Avalon-MM output PIO with atomic set/clear and a one-shot
// pulse engine that inverts selected out_port bits for a programmed number
// of cycles.
// The pulse engine is present only when PIO_OUT_PULSE_EN is defined.
// Register map (word address):
//   0 DATA  1 PULSE_LEN  2 PULSE_MASK  3 STATUS  4 OUTSET  5 OUTCLEAR
module pio_out_pulse #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PULSE_CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_MASK      = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd5;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] data_q,     data_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;

    assign wr           = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign readdata = readdata_q;
    assign out_port = out_port_q;

    // DATA register with plain, set and clear write ports
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d = wdata;
                ADDR_OUTSET: data_d = data_q | wdata;
                ADDR_OUTCLR: data_d = data_q & ~wdata;
                default:     data_d = data_q;
            endcase
        end
    end

`ifdef PIO_OUT_PULSE_EN

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    state_t                 state_q,     state_d;
    logic [PULSE_CNT_W-1:0] pulse_len_q, pulse_len_d;
    logic [PULSE_CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0]       mask_q,      mask_d;
    logic                   done_q,      done_d;
    logic                   pulse_busy_q, pulse_busy_d;

    assign pulse_busy = pulse_busy_q;

    // Pulse engine: start on nonzero mask write, count down, expire or abort
    always_comb begin
        state_d     = state_q;
        pulse_len_d = pulse_len_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        done_d      = done_q;

        if (wr && address == ADDR_PULSE_LEN) begin
            pulse_len_d = writedata[PULSE_CNT_W-1:0];
        end
        // W1C of DONE; an expiry on the same edge below overrides it
        if (wr && address == ADDR_STATUS && writedata[1]) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr && address == ADDR_MASK && wdata != '0) begin
                    state_d = ST_PULSE;
                    mask_d  = wdata;
                    cnt_d   = (pulse_len_q == '0) ? PULSE_CNT_W'(1) : pulse_len_q;
                end
            end
            ST_PULSE: begin
                cnt_d = cnt_q - PULSE_CNT_W'(1);
                if (cnt_q == PULSE_CNT_W'(1)) begin
                    // natural expiry wins over a simultaneous abort
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (wr && address == ADDR_STATUS && writedata[0]) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output pins and busy flag follow the post-edge register state
    always_comb begin
        pulse_busy_d = (state_d == ST_PULSE);
        out_port_d   = data_d ^ (pulse_busy_d ? mask_d : '0);
    end

    // Read mux over the current register state
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:      readdata_d = 32'(data_q);
            ADDR_PULSE_LEN: readdata_d = 32'(pulse_len_q);
            ADDR_MASK:      readdata_d = 32'(mask_q);
            ADDR_STATUS:    readdata_d = {30'd0, done_q, state_q == ST_PULSE};
            default:        readdata_d = '0;
        endcase
    end

    // Pulse engine registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pulse_len_q  <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            pulse_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_len_q  <= pulse_len_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            done_q       <= done_d;
            pulse_busy_q <= pulse_busy_d;
        end
    end

`else

    assign pulse_busy = 1'b0;

    // Output pins mirror DATA directly when there is no pulse engine
    always_comb begin
        out_port_d = data_d;
    end

    // Read mux; pulse registers are absent and read as zero
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(data_q);
            default:   readdata_d = '0;
        endcase
    end

`endif

    // Data, pin and read-back registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            readdata_q <= '0;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            readdata_q <= readdata_d;
            out_port_q <= out_port_d;
        end
    end

endmodule

// File: tb/tb_pio_out_pulse.sv
// Testbench for pio_out_pulse: directed scenarios followed by random bus
// traffic, checked against a time-based model of the register file and
// pulse window. Follows PIO_OUT_PULSE_EN to pick the expected behaviour.
module tb_pio_out_pulse;

    localparam int unsigned WIDTH = 8;
    localparam logic [7:0]  RV    = 8'hA5;
    localparam int unsigned CW    = 16;
`ifdef PIO_OUT_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_busy;

    pio_out_pulse #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .PULSE_CNT_W (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pulse described as a window of edge numbers
    logic [7:0]  m_data;
    logic [15:0] m_len;
    logic [7:0]  m_mask;
    bit          m_on;
    bit          m_done;
    longint      m_end;
    longint      cyc;

    int nvec;
    int nerr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r = {24'd0, m_data};
            3'd1: r = PULSE_EN ? {16'd0, m_len} : 32'd0;
            3'd2: r = PULSE_EN ? {24'd0, m_mask} : 32'd0;
            3'd3: r = PULSE_EN ? {30'd0, m_done, m_on} : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_data = RV;
        m_len  = 16'd0;
        m_mask = 8'd0;
        m_on   = 1'b0;
        m_done = 1'b0;
        m_end  = 0;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] exp_rd);
        logic [7:0] exp_out;
        exp_out = m_data ^ (m_on ? m_mask : 8'h00);
        check({tag, ".out_port"},   {24'd0, out_port},   {24'd0, exp_out});
        check({tag, ".pulse_busy"}, {31'd0, pulse_busy}, {31'd0, m_on});
        check({tag, ".readdata"},   readdata,            exp_rd);
    endtask

    // One bus cycle: drive, clock, update model, check after the edge
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        bit          wr;
        bit          on_before;
        longint      plen;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        exp_rd     = model_read(a);
        @(posedge clk);
        cyc++;
        wr        = cs && !wn;
        on_before = m_on;
        if (wr) begin
            case (a)
                3'd0: m_data = d[7:0];
                3'd4: m_data = m_data | d[7:0];
                3'd5: m_data = m_data & ~d[7:0];
                3'd1: if (PULSE_EN) m_len = d[15:0];
                3'd2: if (PULSE_EN && !on_before && d[7:0] != 8'd0) begin
                    plen   = (m_len == 16'd0) ? 1 : longint'(m_len);
                    m_on   = 1'b1;
                    m_mask = d[7:0];
                    m_end  = cyc + plen;
                end
                3'd3: if (PULSE_EN) begin
                    if (d[1]) m_done = 1'b0;
                    if (d[0] && on_before && cyc < m_end) begin
                        m_on   = 1'b0;
                        m_mask = 8'd0;
                    end
                end
                default: ;
            endcase
        end
        if (m_on && cyc >= m_end) begin
            m_on   = 1'b0;
            m_mask = 8'd0;
            m_done = 1'b1;
        end
        #1;
        check_outputs("step", exp_rd);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, a, 32'd0);
    endtask

    // Asynchronous reset: outputs must settle without a clock edge
    task automatic reset_dut();
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_async", 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs("reset_held", 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        logic        rcs;
        logic        rwn;
        nvec       = 0;
        nerr       = 0;
        cyc        = 0;
        reset      = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        model_reset();
        #2;
        reset_dut();

        // DATA readback one cycle after address
        idle(3'd0, 2);
        check("data_read_a5", readdata, 32'h0000_00A5);

        // Set/clear sequence
        wr_reg(3'd0, 32'h0000_000F);
        check("set_clr_0f", {24'd0, out_port}, 32'h0F);
        wr_reg(3'd4, 32'h0000_0030);
        check("set_clr_3f", {24'd0, out_port}, 32'h3F);
        wr_reg(3'd5, 32'h0000_0003);
        check("set_clr_3c", {24'd0, out_port}, 32'h3C);

        // 5-cycle pulse, DONE readback and W1C
        wr_reg(3'd0, 32'h0);
        wr_reg(3'd1, 32'd5);
        wr_reg(3'd2, 32'h81);
        idle(3'd3, 7);
        wr_reg(3'd3, 32'h2);
        idle(3'd3, 2);

        // Zero length behaves as one cycle
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd2, 32'h01);
        idle(3'd2, 3);

        // Retrigger mid-pulse is ignored
        wr_reg(3'd1, 32'd10);
        wr_reg(3'd2, 32'h0C);
        idle(3'd2, 4);
        wr_reg(3'd2, 32'hF0);
        idle(3'd3, 8);

        // Abort at cycle 20 of a 100-cycle pulse
        wr_reg(3'd3, 32'h2);
        wr_reg(3'd1, 32'd100);
        wr_reg(3'd2, 32'hFF);
        idle(3'd2, 19);
        wr_reg(3'd3, 32'h1);
        idle(3'd3, 2);

        // Abort + W1C on the expiry edge: DONE is set
        wr_reg(3'd1, 32'd3);
        wr_reg(3'd2, 32'h55);
        idle(3'd3, 2);
        wr_reg(3'd3, 32'h3);
        idle(3'd3, 2);

        // DATA writes during a pulse keep the mask applied
        wr_reg(3'd1, 32'd6);
        wr_reg(3'd2, 32'h11);
        wr_reg(3'd4, 32'h80);
        wr_reg(3'd5, 32'h01);
        idle(3'd0, 6);

        // Reset in the middle of a pulse
        wr_reg(3'd1, 32'd50);
        wr_reg(3'd2, 32'hFF);
        idle(3'd1, 5);
        reset_dut();
        idle(3'd1, 1);
        idle(3'd2, 1);
        idle(3'd3, 1);

        // Random bus traffic
        for (int i = 0; i < 1500; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rd  = $urandom;
            if (ra == 3'd1) rd = 32'($urandom_range(0, 12));
            if (ra == 3'd3) rd = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)};
            rcs = ($urandom_range(0, 3) != 0);
            rwn = 1'($urandom_range(0, 1));
            step(rcs, rwn, ra, rd);
            if ($urandom_range(0, 299) == 0) reset_dut();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pio_out_pulse.md
# pio_out_pulse

Avalon-MM output PIO: the write-side counterpart of the single-bit input PIOs on the MebX Qsys fabric. Holds a WIDTH-bit output data register with atomic set/clear access, plus a one-shot pulse engine that inverts selected output bits for a programmed number of clock cycles and then restores them. Sits on the Nios II peripheral bus and drives board-level strobes and enables, for example external sync and reset lines.

## Interface
- WIDTH, 8: number of out_port bits (1..32).
- RESET_VALUE, 0: value loaded into the DATA register on reset.
- PULSE_CNT_W, 16: width of the pulse length counter (1..32).

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  registered output pins.
- pulse_busy  out  1  high while a pulse is active.

## Operation
- Write occurs when chipselect=1 and write_n=0. There are no wait states.
- Register map. Unused high bits read as 0.
  - 0 DATA: RW. A write loads writedata[WIDTH-1:0].
  - 1 PULSE_LEN: RW, PULSE_CNT_W bits. A value of 0 behaves as 1.
  - 2 PULSE_MASK: W starts a pulse. R returns the active mask, which is 0 when idle.
  - 3 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear). Writing bit0=1 aborts an active pulse.
  - 4 OUTSET: W only. DATA |= writedata. Reads 0.
  - 5 OUTCLEAR: W only. DATA &= ~writedata. Reads 0.
  - 6, 7: reads 0, writes ignored.
- out_port = DATA ^ (BUSY ? mask : 0), registered.
- Pulse state machine (IDLE, PULSE):
  - IDLE, PULSE_MASK write with a nonzero value: latch mask, load cnt = max(PULSE_LEN,1), go to PULSE.
  - IDLE, PULSE_MASK write of 0: no effect.
  - PULSE: cnt decrements every cycle. When cnt==1, go to IDLE, clear mask, set DONE.
  - PULSE, PULSE_MASK write: ignored. Retriggering is not allowed.
  - PULSE, STATUS write with bit0=1: go to IDLE and clear mask. DONE is not set.
  - Abort and natural expiry on the same edge: go to IDLE and set DONE.
  - DONE set and W1C clear on the same edge: the set wins.
- DATA, OUTSET and OUTCLEAR writes during PULSE update DATA immediately. out_port then shows the new DATA with the mask still applied.
- Reset during PULSE: returns immediately to IDLE with all registers at their reset values.

## Timing
- Reset values:
  - readdata = 0
  - out_port = RESET_VALUE
  - pulse_busy = 0
  - DATA = RESET_VALUE
  - PULSE_LEN = 0
  - mask = 0, DONE = 0, state = IDLE.
- Write to out_port: the edge that samples the write also updates out_port, so the new value is visible in the following cycle.
- Pulse length: inverted bits stay inverted for exactly max(PULSE_LEN,1) cycles, starting from the edge that samples the PULSE_MASK write.
- pulse_busy follows the same timing as the inversion.
- Read latency is 1 cycle. readdata is reloaded every clock from the register selected by address, with no read strobe. It reflects register state after the previous edge.
- Maximum pulse length is 2^PULSE_CNT_W - 1 cycles. The counter never wraps.

## Configuration
- PIO_OUT_PULSE_EN:
  - Defined: the pulse engine and registers 1–3 are present, as described above.
  - Undefined: addresses 1–3 read 0 and writes to them are ignored. pulse_busy is tied to 0 and out_port = DATA. The DATA/OUTSET/OUTCLEAR behaviour is unchanged.

## Test plan
- Reset values: assert reset with WIDTH=8, RESET_VALUE=0xA5 -> out_port=0xA5 and readdata=0. Read addr 0 -> 0x000000A5 one cycle after address is applied.
- Set/clear: write DATA=0x0F, OUTSET 0x30, OUTCLEAR 0x03 -> out_port sequence 0x0F, 0x3F, 0x3C, each visible the cycle after its write.
- Pulse: DATA=0x00, PULSE_LEN=5, PULSE_MASK=0x81 -> out_port=0x81 and pulse_busy=1 for exactly 5 cycles, then 0x00. STATUS reads 0x2. Writing STATUS 0x2 then reads 0x0.
- Zero length and retrigger: PULSE_LEN=0 with MASK 0x01 -> 1-cycle pulse. With PULSE_LEN=10, a second MASK write mid-pulse -> ignored, and the pulse still ends 10 cycles after the first write.
- Abort and reset: PULSE_LEN=100, MASK 0xFF, STATUS bit0 write at cycle 20 -> out_port restored next cycle with DONE=0. Repeat with reset asserted mid-pulse -> immediate return to reset values.
- Macro off: build without PIO_OUT_PULSE_EN and write MASK 0xFF -> out_port unchanged, pulse_busy=0, addresses 1–3 read 0.
